// File: rtl/frame_scheduler.sv
// Frame sequencer: scene wait, clear, draw, drain, vsync-aligned buffer swap.
// Define FRAME_STATS_EN to build the frame_count/dropped_frames counters.
module frame_scheduler #(
  parameter int unsigned TIMEOUT_CYCLES = 2**22,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             create_done,
  input  logic             vsync,
  input  logic             clear_done,
  input  logic             draw_done,
  input  logic             raster_idle,
  input  logic             err_clear,
  output logic             clear_start,
  output logic             draw_start,
  output logic             buf_swap,
  output logic             front_buf_sel,
  output logic [CNT_W-1:0] frame_count,
  output logic [CNT_W-1:0] dropped_frames,
  output logic             timeout_err,
  output logic             busy
);

  localparam int unsigned WD_W =
    (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_WAIT_SCENE,
    S_CLEAR,
    S_DRAW,
    S_DRAIN,
    S_WAIT_VSYNC,
    S_SWAP,
    S_ERROR
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      sync_q;
  logic            create_sync;
  logic [WD_W-1:0] wd_q;
  logic            clear_start_q;
  logic            draw_start_q;
  logic            buf_swap_q;
  logic            front_q;
  logic            timeout_q;
  logic            busy_q;
  logic            wd_hit;

  assign create_sync = sync_q[1];
  assign wd_hit      = (wd_q == WD_MAX);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT_SCENE: if (create_sync) state_d = S_CLEAR;
      // clear_done in the pulse cycle is stale and ignored
      S_CLEAR: if (clear_done && !clear_start_q) state_d = S_DRAW;
      S_DRAW: begin
        if (draw_done)   state_d = S_DRAIN;
        else if (wd_hit) state_d = S_ERROR;
      end
      S_DRAIN:      if (raster_idle) state_d = S_WAIT_VSYNC;
      S_WAIT_VSYNC: if (vsync) state_d = S_SWAP;
      S_SWAP:       state_d = create_sync ? S_CLEAR : S_WAIT_SCENE;
      S_ERROR:      if (err_clear) state_d = S_WAIT_SCENE;
      default:      state_d = S_WAIT_SCENE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_WAIT_SCENE;
      sync_q        <= '0;
      wd_q          <= '0;
      clear_start_q <= 1'b0;
      draw_start_q  <= 1'b0;
      buf_swap_q    <= 1'b0;
      front_q       <= 1'b0;
      timeout_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      sync_q        <= {sync_q[0], create_done};
      state_q       <= state_d;
      clear_start_q <= (state_d == S_CLEAR) && (state_q != S_CLEAR);
      draw_start_q  <= (state_d == S_DRAW) && (state_q != S_DRAW);
      buf_swap_q    <= (state_d == S_SWAP);
      busy_q        <= state_d inside
                       {S_CLEAR, S_DRAW, S_DRAIN, S_WAIT_VSYNC};
      if (state_d == S_SWAP) front_q <= ~front_q;
      if (state_q == S_DRAW) wd_q <= wd_q + WD_W'(1);
      else                   wd_q <= '0;
      if (state_q == S_DRAW && state_d == S_ERROR)
        timeout_q <= 1'b1;
      else if (state_q == S_ERROR && err_clear)
        timeout_q <= 1'b0;
    end
  end

  assign clear_start   = clear_start_q;
  assign draw_start    = draw_start_q;
  assign buf_swap      = buf_swap_q;
  assign front_buf_sel = front_q;
  assign timeout_err   = timeout_q;
  assign busy          = busy_q;

`ifdef FRAME_STATS_EN
  logic [CNT_W-1:0] frame_cnt_q;
  logic [CNT_W-1:0] drop_cnt_q;
  logic             drop_hit;

  assign drop_hit = vsync &&
    (state_q inside {S_CLEAR, S_DRAW, S_DRAIN});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      if (state_d == S_SWAP)
        frame_cnt_q <= frame_cnt_q + CNT_W'(1);
      if (drop_hit && drop_cnt_q != '1)
        drop_cnt_q <= drop_cnt_q + CNT_W'(1);
    end
  end

  assign frame_count    = frame_cnt_q;
  assign dropped_frames = drop_cnt_q;
`else
  assign frame_count    = '0;
  assign dropped_frames = '0;
`endif

endmodule

// File: tb/tb_frame_scheduler.sv
// Randomized scoreboard bench for frame_scheduler.
// Expected pulses come from a per-frame timeline model.
module tb_frame_scheduler;

  localparam int TO = 64;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          create_done;
  logic          vsync;
  logic          clear_done;
  logic          draw_done;
  logic          raster_idle;
  logic          err_clear;
  logic          clear_start;
  logic          draw_start;
  logic          buf_swap;
  logic          front_buf_sel;
  logic [CW-1:0] frame_count;
  logic [CW-1:0] dropped_frames;
  logic          timeout_err;
  logic          busy;

  frame_scheduler #(
    .TIMEOUT_CYCLES(TO),
    .CNT_W         (CW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .create_done   (create_done),
    .vsync         (vsync),
    .clear_done    (clear_done),
    .draw_done     (draw_done),
    .raster_idle   (raster_idle),
    .err_clear     (err_clear),
    .clear_start   (clear_start),
    .draw_start    (draw_start),
    .buf_swap      (buf_swap),
    .front_buf_sel (front_buf_sel),
    .frame_count   (frame_count),
    .dropped_frames(dropped_frames),
    .timeout_err   (timeout_err),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int kind;
    int at;
    bit front;
    int fc;
    int dr;
  } evt_t;

  evt_t q[$];
  int   checks = 0;
  int   errors = 0;

  int   vs_next;
  int   drops_m;
  int   frames_m;
  bit   front_m;

  function automatic string nm(input int k);
    case (k)
      0: return "clear_start";
      1: return "draw_start";
      2: return "buf_swap";
      default: return "timeout_err";
    endcase
  endfunction

  function automatic int ex(input int v);
`ifdef FRAME_STATS_EN
    return v;
`else
    return 0;
`endif
  endfunction

  task automatic chk(input string name, input longint act,
                     input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic take(input int kind);
    evt_t e;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected %s: got pulse expected none (cycle %0d)",
               nm(kind), cyc);
      return;
    end
    e = q.pop_front();
    chk({"event kind ", nm(kind)}, kind, e.kind);
    chk({"event cycle ", nm(kind)}, cyc, e.at);
    chk({"front_buf_sel @", nm(kind)}, front_buf_sel, e.front);
    chk({"frame_count @", nm(kind)}, frame_count, ex(e.fc));
    chk({"dropped_frames @", nm(kind)}, dropped_frames, ex(e.dr));
    chk({"busy @", nm(kind)}, busy, (kind < 2) ? 1 : 0);
  endtask

  logic to_prev = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (clear_start) take(0);
      if (draw_start) take(1);
      if (buf_swap) take(2);
      if (timeout_err && !to_prev) take(3);
    end
    to_prev <= timeout_err;
  end

  task automatic push(input int k, input int at);
    evt_t e;
    e.kind  = k;
    e.at    = at;
    e.front = front_m;
    e.fc    = frames_m;
    e.dr    = drops_m;
    q.push_back(e);
  endtask

  // Advance to the next cycle; cnt marks vsyncs that count as drops.
  task automatic tick(input bit cnt, input bit errok);
    @(negedge clk);
    vsync = (cyc == vs_next);
    if (vsync) begin
      vs_next = cyc + int'($urandom_range(3, 60));
      if (cnt && drops_m < 65535) drops_m++;
    end
    err_clear = errok && ($urandom_range(0, 15) == 0);
  endtask

  task automatic scene_start(output int tc);
    int w;
    w = $urandom_range(2, 12);
    for (int i = 0; i < w; i++) tick(0, 1);
    tick(0, 1);
    create_done = 1'b1;
    tick(0, 1);
    tick(0, 1);
    push(0, cyc + 1);
    tc = cyc + 1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " clear_start"}, clear_start, 0);
    chk({tag, " draw_start"}, draw_start, 0);
    chk({tag, " buf_swap"}, buf_swap, 0);
    chk({tag, " front_buf_sel"}, front_buf_sel, 0);
    chk({tag, " frame_count"}, frame_count, 0);
    chk({tag, " dropped_frames"}, dropped_frames, 0);
    chk({tag, " timeout_err"}, timeout_err, 0);
    chk({tag, " busy"}, busy, 0);
  endtask

  task automatic do_reset(output int ntc);
    chk("frame_count before reset", frame_count, ex(frames_m));
    chk("pending before reset", q.size(), 0);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("async reset");
    create_done = 1'b0;
    clear_done  = 1'b0;
    raster_idle = 1'b1;
    repeat (3) tick(0, 1);
    rst_n    = 1'b1;
    front_m  = 1'b0;
    frames_m = 0;
    drops_m  = 0;
    scene_start(ntc);
  endtask

  // mode 0 normal, 1 create drop in DRAW, 2 draw hang, 3 reset in DRAIN
  task automatic run_frame(input int mode, output int ntc);
    int lc, ld, lr, w;
    bit stale, got;
    lc = ($urandom_range(0, 4) == 0) ? $urandom_range(20, 150)
                                      : $urandom_range(1, 8);
    ld = $urandom_range(0, 30);
    lr = (mode == 3) ? $urandom_range(3, 8) : $urandom_range(0, 6);
    stale = $urandom_range(0, 1);
    for (int i = 0; i <= lc; i++) begin
      tick(1, 1);
      clear_done  = (i == lc) || (stale && i == 0);
      draw_done   = 1'b0;
      raster_idle = 1'b1;
    end
    push(1, cyc + 1);
    if (mode == 2) begin
      for (int i = 0; i < TO; i++) begin
        tick(1, 1);
        draw_done   = 1'b0;
        raster_idle = 1'b0;
        clear_done  = 1'b0;
      end
      push(3, cyc + 1);
      w = $urandom_range(3, 20);
      for (int i = 0; i < w; i++) tick(0, 0);
      tick(0, 0);
      chk("timeout_err held in ERROR", timeout_err, 1);
      chk("busy in ERROR", busy, 0);
      err_clear = 1'b1;
      push(0, cyc + 2);
      tick(0, 0);
      chk("timeout_err after err_clear", timeout_err, 0);
      chk("busy after err_clear", busy, 0);
      ntc = cyc + 1;
      return;
    end
    for (int i = 0; i <= ld; i++) begin
      tick(1, 1);
      draw_done   = (i == ld);
      raster_idle = 1'b0;
      clear_done  = 1'b0;
      if (mode == 1 && i == 0) create_done = 1'b0;
    end
    for (int i = 0; i <= lr; i++) begin
      tick(1, 1);
      raster_idle = (i == lr);
      draw_done   = 1'b0;
      if (mode == 3 && i == 1) begin
        do_reset(ntc);
        return;
      end
    end
    got = 1'b0;
    for (int g = 0; g < 200 && !got; g++) begin
      tick(0, 1);
      got = vsync;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL vsync wait: got none expected one (cycle %0d)", cyc);
    end
    front_m = ~front_m;
    frames_m++;
    push(2, cyc + 1);
    if (mode != 1) push(0, cyc + 2);
    tick(0, 1);
    if (mode == 1) scene_start(ntc);
    else ntc = cyc + 1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL sim bound: got no finish expected finish");
    $fatal(1, "simulation bound reached");
  end

  initial begin
    int tc, mode, r;
    rst_n       = 1'b0;
    create_done = 1'b0;
    clear_done  = 1'b0;
    draw_done   = 1'b0;
    raster_idle = 1'b1;
    vsync       = 1'b0;
    err_clear   = 1'b0;
    drops_m     = 0;
    frames_m    = 0;
    front_m     = 1'b0;
    vs_next     = 1 << 30;
    repeat (3) @(negedge clk);
    chk_reset_vals("power-on reset");
    rst_n   = 1'b1;
    vs_next = cyc + 15;
    scene_start(tc);
    for (int f = 0; f < 30; f++) begin
      if (f == 2)      mode = 2;
      else if (f == 4) mode = 1;
      else if (f == 6) mode = 3;
      else if (f < 6)  mode = 0;
      else begin
        r = $urandom_range(0, 9);
        mode = (r == 0) ? 2 : (r < 3) ? 1 : 0;
      end
      run_frame(mode, tc);
    end
    repeat (5) tick(0, 1);
    chk("pending events at end", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
